axi_lite_mem_slave: RTL and testbench



---
 rtl/axi_lite_mem_slave_if.sv | 35 +++
 rtl/axi_lite_mem_slave.sv | 190 +++++++++++++++++++
 tb/tb_axi_lite_mem_slave.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite bus bundle for a single master/slave link (no clock or reset inside).
// Write strobes carry one extra upper bit that is kept for compatibility with the wider bus and has no effect.
interface axi_lite_mem_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8:0]   wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [RESP_WIDTH-1:0]   bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [RESP_WIDTH-1:0]   rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite register memory: independent write (AW/W/B) and read (AR/R) engines over a small word array.
// Out-of-range accesses answer SLVERR and leave the memory untouched; all outputs are registered.
module axi_lite_mem_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter int DEPTH      = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_aresetn,
    axi_lite_mem_slave_if.slave s_axi
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   BASE_X = (ADDR_WIDTH + 1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   SPAN   = (ADDR_WIDTH + 1)'(DEPTH * 4);

    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_WAIT = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    // Offset is taken modulo 2**ADDR_WIDTH; the lower-bound compare rejects wrapped addresses.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} >= BASE_X) && ({1'b0, a - BASE_A} < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_A) >> 2);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]            w_state_reg;
    logic                  awready_reg, wready_reg, bvalid_reg;
    logic [RESP_WIDTH-1:0] bresp_reg;
    logic                  aw_held_reg, w_held_reg;
    logic [ADDR_WIDTH-1:0] awaddr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [NB-1:0]         wstrb_reg;

    logic [0:0]            r_state_reg;
    logic                  arready_reg, rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [RESP_WIDTH-1:0] rresp_reg;

    logic                  aw_fire, w_fire, have_aw, have_w, wr_commit, wr_ok;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data, wr_mask;
    logic [NB-1:0]         wr_strb;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  ar_fire, rd_ok;
    logic                  unused_strb_msb;

    // A beat arriving on this edge is used directly so AW and W may complete in the same cycle.
    assign aw_fire   = s_axi.awvalid & awready_reg;
    assign w_fire    = s_axi.wvalid & wready_reg;
    assign have_aw   = aw_held_reg | aw_fire;
    assign have_w    = w_held_reg | w_fire;
    assign wr_commit = (w_state_reg != W_RESP) && have_aw && have_w;
    assign wr_addr   = aw_fire ? s_axi.awaddr : awaddr_reg;
    assign wr_data   = w_fire ? s_axi.wdata : wdata_reg;
    assign wr_strb   = w_fire ? s_axi.wstrb[NB-1:0] : wstrb_reg;
    assign wr_ok     = addr_in_range(wr_addr);
    assign wr_idx    = word_index(wr_addr);

    assign unused_strb_msb = s_axi.wstrb[NB];

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_byte_mask
            assign wr_mask[gi*8 +: 8] = {8{wr_strb[gi]}};
        end
    endgenerate

    assign ar_fire = s_axi.arvalid & arready_reg;
    assign rd_ok   = addr_in_range(s_axi.araddr);
    assign rd_idx  = word_index(s_axi.araddr);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_commit && wr_ok) begin
            mem[wr_idx] <= (mem[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state_reg <= W_IDLE;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= '0;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
        end else begin
            case (w_state_reg)
                W_IDLE, W_WAIT: begin
                    if (wr_commit) begin
                        bvalid_reg  <= 1'b1;
                        bresp_reg   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        awready_reg <= 1'b0;
                        wready_reg  <= 1'b0;
                        aw_held_reg <= 1'b0;
                        w_held_reg  <= 1'b0;
                        w_state_reg <= W_RESP;
                    end else begin
                        if (aw_fire) begin
                            awaddr_reg  <= s_axi.awaddr;
                            aw_held_reg <= 1'b1;
                        end
                        if (w_fire) begin
                            wdata_reg  <= s_axi.wdata;
                            wstrb_reg  <= s_axi.wstrb[NB-1:0];
                            w_held_reg <= 1'b1;
                        end
                        // Also raises both readies on the first edge after reset release.
                        awready_reg <= !have_aw;
                        wready_reg  <= !have_w;
                        w_state_reg <= (have_aw || have_w) ? W_WAIT : W_IDLE;
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_reg  <= 1'b0;
                        awready_reg <= 1'b1;
                        wready_reg  <= 1'b1;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: begin
                    w_state_reg <= W_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state_reg <= R_IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            rresp_reg   <= '0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (ar_fire) begin
                        // Sees the pre-write word when a write commits to it on the same edge.
                        rdata_reg   <= rd_ok ? mem[rd_idx] : '0;
                        rresp_reg   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        rvalid_reg  <= 1'b1;
                        arready_reg <= 1'b0;
                        r_state_reg <= R_RESP;
                    end else begin
                        arready_reg <= 1'b1;
                    end
                end
                default: begin
                    if (s_axi.rready) begin
                        rvalid_reg  <= 1'b0;
                        arready_reg <= 1'b1;
                        r_state_reg <= R_IDLE;
                    end
                end
            endcase
        end
    end

    assign s_axi.awready = awready_reg;
    assign s_axi.wready  = wready_reg;
    assign s_axi.bvalid  = bvalid_reg;
    assign s_axi.bresp   = bresp_reg;
    assign s_axi.arready = arready_reg;
    assign s_axi.rvalid  = rvalid_reg;
    assign s_axi.rdata   = rdata_reg;
    assign s_axi.rresp   = rresp_reg;
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed bench for axi_lite_mem_slave: stimulus pushes expected B/R responses into queues,
// a negedge monitor pops and compares them on every B and R handshake.
module tb_axi_lite_mem_slave;
    localparam logic [2:0] OKAY   = 3'd0;
    localparam logic [2:0] SLVERR = 3'd2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [2:0]  exp_b_q [$];
    logic [34:0] exp_r_q [$];
    logic [2:0]  mon_b;
    logic [34:0] mon_r;

    axi_lite_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3)) bus ();

    axi_lite_mem_slave #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .RESP_WIDTH(3),
        .DEPTH     (4),
        .BASE_ADDR (0)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rst_n),
        .s_axi        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no handshake within 50 cycles expected one", name);
    endtask

    // Scoreboard monitor: one pop per B or R handshake (sampled mid-cycle, before the edge that completes it).
    always @(negedge clk) begin
        if (rst_n && bus.bvalid && bus.bready) begin
            if (exp_b_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected: got bresp=%0d expected no response", bus.bresp);
            end else begin
                mon_b = exp_b_q.pop_front();
                check("bresp", 32'(bus.bresp), 32'(mon_b));
            end
        end
        if (rst_n && bus.rvalid && bus.rready) begin
            if (exp_r_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL r_unexpected: got rdata=0x%08h expected no response", bus.rdata);
            end else begin
                mon_r = exp_r_q.pop_front();
                check("rdata", bus.rdata, mon_r[31:0]);
                check("rresp", 32'(bus.rresp), 32'(mon_r[34:32]));
            end
        end
    end

    // ch bit 0 = awready, 1 = wready, 2 = arready; returns just after the handshake edge.
    task automatic wait_ready(input string name, input logic [2:0] ch);
        int n = 0;
        forever begin
            @(negedge clk);
            if ((!ch[0] || bus.awready) && (!ch[1] || bus.wready) && (!ch[2] || bus.arready)) break;
            n++;
            if (n > 50) begin
                timeout_fail(name);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // order: 0 = AW and W together, 1 = AW three cycles before W, 2 = W three cycles before AW.
    task automatic send_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                              input int order, input logic [2:0] er);
        exp_b_q.push_back(er);
        @(posedge clk);
        #1;
        bus.awaddr = a;
        bus.wdata  = d;
        bus.wstrb  = s;
        if (order == 0) begin
            bus.awvalid = 1'b1;
            bus.wvalid  = 1'b1;
            wait_ready("aw_w_ready", 3'b011);
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
        end else if (order == 1) begin
            bus.awvalid = 1'b1;
            wait_ready("aw_ready", 3'b001);
            bus.awvalid = 1'b0;
            repeat (3) begin
                @(negedge clk);
                check("aw_first_awready", 32'(bus.awready), 32'd0);
                check("aw_first_wready", 32'(bus.wready), 32'd1);
                check("aw_first_bvalid", 32'(bus.bvalid), 32'd0);
            end
            @(posedge clk);
            #1;
            bus.wvalid = 1'b1;
            wait_ready("w_ready", 3'b010);
            bus.wvalid = 1'b0;
        end else begin
            bus.wvalid = 1'b1;
            wait_ready("w_ready", 3'b010);
            bus.wvalid = 1'b0;
            repeat (3) begin
                @(negedge clk);
                check("w_first_wready", 32'(bus.wready), 32'd0);
                check("w_first_awready", 32'(bus.awready), 32'd1);
                check("w_first_bvalid", 32'(bus.bvalid), 32'd0);
            end
            @(posedge clk);
            #1;
            bus.awvalid = 1'b1;
            wait_ready("aw_ready", 3'b001);
            bus.awvalid = 1'b0;
        end
        @(negedge clk);
        check("b_latency", 32'(bus.bvalid), 32'd1);
    endtask

    task automatic send_read(input logic [7:0] a, input logic [31:0] ed, input logic [2:0] er);
        exp_r_q.push_back({er, ed});
        @(posedge clk);
        #1;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        wait_ready("ar_ready", 3'b100);
        bus.arvalid = 1'b0;
        @(negedge clk);
        check("r_latency", 32'(bus.rvalid), 32'd1);
    endtask

    task automatic wait_b();
        int n = 0;
        while (!(bus.bvalid && bus.bready)) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                timeout_fail("b_handshake");
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_r();
        int n = 0;
        while (!(bus.rvalid && bus.rready)) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                timeout_fail("r_handshake");
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic read_word(input logic [7:0] a, input logic [31:0] ed, input logic [2:0] er);
        send_read(a, ed, er);
        wait_r();
    endtask

    task automatic write_word(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                              input int order, input logic [2:0] er);
        send_write(a, d, s, order, er);
        wait_b();
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_awready"}, 32'(bus.awready), 32'd0);
        check({tag, "_wready"}, 32'(bus.wready), 32'd0);
        check({tag, "_arready"}, 32'(bus.arready), 32'd0);
        check({tag, "_bvalid"}, 32'(bus.bvalid), 32'd0);
        check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
        check({tag, "_bresp"}, 32'(bus.bresp), 32'd0);
        check({tag, "_rresp"}, 32'(bus.rresp), 32'd0);
        check({tag, "_rdata"}, bus.rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;

        // Reset state and ready rise on the first edge after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_low("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("release_awready_pre", 32'(bus.awready), 32'd0);
        @(negedge clk);
        check("release_awready", 32'(bus.awready), 32'd1);
        check("release_wready", 32'(bus.wready), 32'd1);
        check("release_arready", 32'(bus.arready), 32'd1);

        // Basic write/read, AW and W together
        write_word(8'h00, 32'h0000_0038, 5'h0F, 0, OKAY);
        read_word(8'h00, 32'h0000_0038, OKAY);

        // Byte strobes; the extra strobe bit 4 has no effect
        write_word(8'h04, 32'hAABB_CCDD, 5'h0F, 0, OKAY);
        write_word(8'h04, 32'h1122_3344, 5'h12, 0, OKAY);
        read_word(8'h04, 32'hAABB_33DD, OKAY);

        // AW before W, then W before AW; low address bits are ignored
        write_word(8'h08, 32'h1234_5678, 5'h0F, 1, OKAY);
        read_word(8'h08, 32'h1234_5678, OKAY);
        write_word(8'h0C, 32'hCAFE_F00D, 5'h0F, 2, OKAY);
        read_word(8'h0E, 32'hCAFE_F00D, OKAY);

        // Out of range: first word past the end and a far address
        write_word(8'h40, 32'hFFFF_FFFF, 5'h0F, 0, SLVERR);
        write_word(8'h10, 32'hFFFF_FFFF, 5'h0F, 0, SLVERR);
        read_word(8'h40, 32'h0000_0000, SLVERR);
        read_word(8'h10, 32'h0000_0000, SLVERR);
        read_word(8'h00, 32'h0000_0038, OKAY);
        read_word(8'h04, 32'hAABB_33DD, OKAY);
        read_word(8'h08, 32'h1234_5678, OKAY);
        read_word(8'h0C, 32'hCAFE_F00D, OKAY);

        // Write commit and read capture to the same word on the same edge
        fork
            write_word(8'h00, 32'h0000_0055, 5'h0F, 0, OKAY);
            read_word(8'h00, 32'h0000_0038, OKAY);
        join
        read_word(8'h00, 32'h0000_0055, OKAY);

        // Back-pressure: responses held stable, no new transactions accepted
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        fork
            send_write(8'h08, 32'hDEAD_BEEF, 5'h0F, 0, OKAY);
            send_read(8'h04, 32'hAABB_33DD, OKAY);
        join
        repeat (5) begin
            @(negedge clk);
            check("hold_bvalid", 32'(bus.bvalid), 32'd1);
            check("hold_bresp", 32'(bus.bresp), 32'd0);
            check("hold_rvalid", 32'(bus.rvalid), 32'd1);
            check("hold_rdata", bus.rdata, 32'hAABB_33DD);
            check("hold_awready", 32'(bus.awready), 32'd0);
            check("hold_wready", 32'(bus.wready), 32'd0);
            check("hold_arready", 32'(bus.arready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        @(negedge clk);
        check("release_pending_awready", 32'(bus.awready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("after_hold_awready", 32'(bus.awready), 32'd1);
        check("after_hold_wready", 32'(bus.wready), 32'd1);
        check("after_hold_arready", 32'(bus.arready), 32'd1);
        check("after_hold_bvalid", 32'(bus.bvalid), 32'd0);
        check("after_hold_rvalid", 32'(bus.rvalid), 32'd0);
        read_word(8'h08, 32'hDEAD_BEEF, OKAY);

        // Reset with the write engine waiting for W and the read engine holding a response
        bus.rready  = 1'b0;
        bus.awaddr  = 8'h00;
        bus.awvalid = 1'b1;
        bus.araddr  = 8'h04;
        bus.arvalid = 1'b1;
        wait_ready("aw_ar_ready", 3'b101);
        bus.awvalid = 1'b0;
        bus.arvalid = 1'b0;
        @(negedge clk);
        check("mid_rvalid", 32'(bus.rvalid), 32'd1);
        check("mid_rdata", bus.rdata, 32'hAABB_33DD);
        check("mid_awready", 32'(bus.awready), 32'd0);
        check("mid_wready", 32'(bus.wready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_low("async_reset");
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        bus.rready = 1'b1;
        read_word(8'h00, 32'h0000_0000, OKAY);
        read_word(8'h04, 32'h0000_0000, OKAY);
        read_word(8'h08, 32'h0000_0000, OKAY);
        read_word(8'h0C, 32'h0000_0000, OKAY);
        write_word(8'h0C, 32'h600D_F00D, 5'h0F, 0, OKAY);
        read_word(8'h0C, 32'h600D_F00D, OKAY);

        repeat (2) @(negedge clk);
        check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);
        check("r_queue_drained", 32'(exp_r_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
